// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the 8-bit APB timer: counter width, wrap boundary
// and the counter value type used by the timer blocks.
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int TIMER_WIDTH = 8;

  typedef logic [TIMER_WIDTH-1:0] count_t;

  localparam count_t TIMER_MAX = 8'hFF;

endpackage : timer_pkg

// File: rtl/comparator_if.sv
// ---------------------------------------------------------------------------
// comparator_if
// Bundle between the timer counter / status register and the wrap detector.
//   COUNT_IN    counter value presented each PCLK           (master -> slave)
//   LAST_COUNT  COUNT_IN sampled at the previous edge       (slave -> master)
//   flag_ovf    one-cycle pulse on a MAX_VAL -> 0 wrap      (slave -> master)
//   flag_udf    one-cycle pulse on a 0 -> MAX_VAL wrap      (slave -> master)
// Optional, only when COMPARATOR_STICKY_EN is defined:
//   sticky_clr  clears both sticky bits at an edge          (master -> slave)
//   ovf_sticky  set by an overflow, held until cleared      (slave -> master)
//   udf_sticky  set by an underflow, held until cleared     (slave -> master)
// ---------------------------------------------------------------------------
interface comparator_if
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
);

  logic [WIDTH-1:0] COUNT_IN;
  logic [WIDTH-1:0] LAST_COUNT;
  logic             flag_ovf;
  logic             flag_udf;
`ifdef COMPARATOR_STICKY_EN
  logic             sticky_clr;
  logic             ovf_sticky;
  logic             udf_sticky;
`endif

`ifdef COMPARATOR_STICKY_EN
  modport master (
    output COUNT_IN, sticky_clr,
    input  LAST_COUNT, flag_ovf, flag_udf, ovf_sticky, udf_sticky
  );

  modport slave (
    input  COUNT_IN, sticky_clr,
    output LAST_COUNT, flag_ovf, flag_udf, ovf_sticky, udf_sticky
  );
`else
  modport master (
    output COUNT_IN,
    input  LAST_COUNT, flag_ovf, flag_udf
  );

  modport slave (
    input  COUNT_IN,
    output LAST_COUNT, flag_ovf, flag_udf
  );
`endif

endinterface : comparator_if

// File: rtl/comparator_wrap_detect.sv
// ---------------------------------------------------------------------------
// wrap_detect
// Purely combinational boundary-pair detector for the timer counter.
//   prev     previous counter sample
//   curr     current counter value
//   ovf_hit  prev == MAX_VAL and curr == 0       (up-count wrap)
//   udf_hit  prev == 0       and curr == MAX_VAL (down-count wrap)
// Only exact boundary pairs count; any other jump (FE->01, 7F->80) is ignored.
// The two hits are mutually exclusive because 0 != MAX_VAL for WIDTH >= 1.
// ---------------------------------------------------------------------------
module wrap_detect #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] curr,
  output logic             ovf_hit,
  output logic             udf_hit
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  always_comb begin
    // NOTE: every output gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    ovf_hit = 1'b0;
    udf_hit = 1'b0;
    if ((prev == MAX_VAL) && (curr == ZERO)) ovf_hit = 1'b1;
    if ((prev == ZERO) && (curr == MAX_VAL)) udf_hit = 1'b1;
  end

endmodule : wrap_detect

// File: rtl/comparator.sv
// ---------------------------------------------------------------------------
// comparator
// Wrap detector for the 8-bit APB timer counter. Samples COUNT_IN each PCLK,
// keeps the previous sample and pulses flag_ovf on a MAX_VAL->0 wrap or
// flag_udf on a 0->MAX_VAL wrap, for one cycle.
//   PCLK    system clock, all logic on the rising edge
//   PRESET  synchronous active-high reset
//   bus     comparator_if.slave: COUNT_IN in; LAST_COUNT, flag_ovf,
//           flag_udf out (plus sticky_clr / ovf_sticky / udf_sticky)
// Optional feature macro: COMPARATOR_STICKY_EN adds sticky status bits that
// hold a seen wrap until sticky_clr (clear wins over a same-cycle set).
// ---------------------------------------------------------------------------
module comparator
  import timer_pkg::*;
#(
  parameter int               WIDTH   = TIMER_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic         PCLK,
  input  logic         PRESET,
  comparator_if.slave  bus
);

  logic [WIDTH-1:0] last_count_q;
  logic             flag_ovf_q;
  logic             flag_udf_q;
  // Set after the first sample following reset. Until then last_count_q
  // holds the reset value 0 rather than a real sample, so a leading FF must
  // not be taken as a 0->FF underflow.
  logic             primed_q;
  logic             ovf_hit;
  logic             udf_hit;

  wrap_detect #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_wrap_detect (
    .prev    (last_count_q),
    .curr    (bus.COUNT_IN),
    .ovf_hit (ovf_hit),
    .udf_hit (udf_hit)
  );

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    if (PRESET) begin
      last_count_q <= '0;
      flag_ovf_q   <= 1'b0;
      flag_udf_q   <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      last_count_q <= bus.COUNT_IN;
      flag_ovf_q   <= primed_q & ovf_hit;
      flag_udf_q   <= primed_q & udf_hit;
      primed_q     <= 1'b1;
    end
  end

  assign bus.LAST_COUNT = last_count_q;
  assign bus.flag_ovf   = flag_ovf_q;
  assign bus.flag_udf   = flag_udf_q;

`ifdef COMPARATOR_STICKY_EN
  logic ovf_sticky_q;
  logic udf_sticky_q;

  // Stickies latch the same condition that registers the pulse, so they rise
  // together with the flag and then hold.
  always_ff @(posedge PCLK) begin
    if (PRESET || bus.sticky_clr) begin
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_q | (primed_q & ovf_hit);
      udf_sticky_q <= udf_sticky_q | (primed_q & udf_hit);
    end
  end

  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.udf_sticky = udf_sticky_q;
`endif

endmodule : comparator

// File: tb/tb_comparator.sv
// ---------------------------------------------------------------------------
// tb_comparator
// Self-checking bench for the timer wrap detector. Directed scenarios cover
// reset, wraps, non-wrap jumps, held values, alternation and mid-pulse reset;
// a randomized phase follows. Expected values come from a sample-history
// model: the outputs after an edge are derived from the last two samples
// taken since the most recent reset.
// ---------------------------------------------------------------------------
module tb_comparator;
  import timer_pkg::*;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  int n_asserts = 0;
  int n_fail    = 0;

  comparator_if #(.WIDTH(TIMER_WIDTH)) bus ();

  comparator #(
    .WIDTH   (TIMER_WIDTH),
    .MAX_VAL (TIMER_MAX)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  // Reference model state: samples taken since the last reset (at most 2).
  count_t hist[$];
  logic   exp_ovf_s = 1'b0;
  logic   exp_udf_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one edge, advance the model and compare all outputs
  // 1 ns after the edge.
  task automatic step(input count_t c, input logic rst, input logic clr, input string tag);
    logic   e_ovf;
    logic   e_udf;
    count_t e_last;
    bus.COUNT_IN = c;
    PRESET       = rst;
`ifdef COMPARATOR_STICKY_EN
    bus.sticky_clr = clr;
`endif
    @(posedge PCLK);
    if (rst) begin
      hist.delete();
    end else begin
      hist.push_back(c);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    e_last = (hist.size() > 0) ? hist[hist.size()-1] : count_t'(0);
    e_ovf  = (hist.size() == 2) && (hist[0] == TIMER_MAX) && (hist[1] == 0);
    e_udf  = (hist.size() == 2) && (hist[0] == 0) && (hist[1] == TIMER_MAX);
    if (rst || clr) begin
      exp_ovf_s = 1'b0;
      exp_udf_s = 1'b0;
    end else begin
      exp_ovf_s = exp_ovf_s | e_ovf;
      exp_udf_s = exp_udf_s | e_udf;
    end
    #1;
    check({tag, ".last"}, 32'(bus.LAST_COUNT), 32'(e_last));
    check({tag, ".ovf"},  32'(bus.flag_ovf),   32'(e_ovf));
    check({tag, ".udf"},  32'(bus.flag_udf),   32'(e_udf));
`ifdef COMPARATOR_STICKY_EN
    check({tag, ".ovf_sticky"}, 32'(bus.ovf_sticky), 32'(exp_ovf_s));
    check({tag, ".udf_sticky"}, 32'(bus.udf_sticky), 32'(exp_udf_s));
`else
    if (clr) check({tag, ".clr_unused"}, 32'(clr), 32'(1'b1));
`endif
  endtask

  initial begin
    logic   r;
    logic   k;
    count_t v;
    bus.COUNT_IN = '0;
`ifdef COMPARATOR_STICKY_EN
    bus.sticky_clr = 1'b0;
`endif

    // Reset, then an up-count wrap: one overflow pulse, LAST_COUNT = 00.
    step(8'h5A, 1'b1, 1'b0, "reset");
    step(8'hFF, 1'b0, 1'b0, "up_ff");
    step(8'h00, 1'b0, 1'b0, "up_wrap");
    check("ovf_pulse_fixed", 32'(bus.flag_ovf), 32'd1);
    step(8'h01, 1'b0, 1'b0, "up_01");
    check("ovf_drop_fixed", 32'(bus.flag_ovf), 32'd0);
    step(8'hFE, 1'b0, 1'b0, "up_fe");
    step(8'hFF, 1'b0, 1'b0, "up_ff2");

    // Down-count wrap 00 -> FF, then a held value after the wrap.
    step(8'h00, 1'b0, 1'b0, "dn_00");
    step(8'hFF, 1'b0, 1'b0, "dn_wrap");
    check("udf_pulse_fixed", 32'(bus.flag_udf), 32'd1);
    step(8'hFF, 1'b0, 1'b0, "dn_hold");
    step(8'h00, 1'b0, 1'b0, "hold_wrap");
    step(8'h00, 1'b0, 1'b0, "hold_0a");
    step(8'h00, 1'b0, 1'b0, "hold_0b");

    // Reset released with COUNT_IN = FF: no false underflow on first sample.
    step(8'hFF, 1'b1, 1'b0, "rst_ff");
    step(8'hFF, 1'b0, 1'b0, "first_ff");
    check("first_ff_udf_fixed", 32'(bus.flag_udf), 32'd0);
    check("first_ff_last_fixed", 32'(bus.LAST_COUNT), 32'hFF);

    // Alternating FF,00,FF,00: ovf and udf alternate, never both.
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0, 1'b0, "alt");
      check("alt_exclusive", 32'(bus.flag_ovf & bus.flag_udf), 32'd0);
    end

    // Reset while an overflow pulse is high clears everything at that edge.
    step(8'hFF, 1'b0, 1'b0, "mid_ff");
    step(8'h00, 1'b0, 1'b0, "mid_wrap");
    step(8'h00, 1'b1, 1'b0, "mid_reset");

    // Non-wrap jumps never flag.
    step(8'hFE, 1'b0, 1'b0, "jump_fe");
    step(8'h01, 1'b0, 1'b0, "jump_01");
    step(8'h7F, 1'b0, 1'b0, "jump_7f");
    step(8'h80, 1'b0, 1'b0, "jump_80");

    // Sticky behaviour: wrap, idle, clear; then clear coinciding with a wrap.
    step(8'hFF, 1'b0, 1'b0, "st_ff");
    step(8'h00, 1'b0, 1'b0, "st_wrap");
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0, "st_idle");
`ifdef COMPARATOR_STICKY_EN
    check("sticky_held_fixed", 32'(bus.ovf_sticky), 32'd1);
`endif
    step(8'h00, 1'b0, 1'b1, "st_clr");
    step(8'hFF, 1'b0, 1'b0, "st_udf");
    step(8'hFF, 1'b0, 1'b0, "st_pre");
    step(8'h00, 1'b0, 1'b1, "st_clr_wins");

    // Randomized phase, biased toward boundary values.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'hFF;
        2:       v = count_t'($urandom_range(0, 3)) - 8'd1;
        default: v = count_t'($urandom);
      endcase
      r = ($urandom_range(0, 29) == 0);
      k = ($urandom_range(0, 9) == 0);
`ifndef COMPARATOR_STICKY_EN
      k = 1'b0;
`endif
      step(v, r, k, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_comparator
